// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states and helpers.
package md_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} md_state_e;

  function automatic logic md_is_muldiv(input md_op_t op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath; result packs {hi, lo}.
module md_compute
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  assign div_by_zero = (b == 32'd0) && ((op == MD_DIV) || (op == MD_DIVU));

  // A zero divisor is swapped for one so the dividers never see 0; the result is discarded.
  assign div_b = (b == 32'd0) ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quot_s = $signed(a) / $signed(div_b);
  assign rem_s  = $signed(a) % $signed(div_b);
  assign quot_u = a / div_b;
  assign rem_u  = a % div_b;

  always_comb begin
    result = '0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, models fixed latencies, raises stall.
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        md_use_d,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  md_op_t          op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;

  logic [63:0]     result;
  logic            div_by_zero;

  md_compute u_compute (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    // cancel wins over both an in-flight op and a same-cycle start
    if (cancel) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (md_is_muldiv(op)) begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
              state_d = StRun;
            end else if (op == MD_MTHI) begin
              hi_d = a;
            end else if (op == MD_MTLO) begin
              lo_d = a;
            end
          end
        end
        StRun: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (!div_by_zero) begin
              {hi_d, lo_d} = result;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Covers the start cycle too, so a dependent MFHI in D never slips past
  assign stall = md_use_d & (busy | (start & md_is_muldiv(op)));

endmodule
